mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum ACCESS cycles before abort; legal range 1..255.
REQ-002 The block SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port MemRead_i, input, 1, load flag from EX/MEM register.
REQ-005 The block SHALL have port MemWrite_i, input, 1, store flag from EX/MEM register.
REQ-006 The block SHALL have port addr_i, input, 32, ALU result from EX/MEM (memory address).
REQ-007 The block SHALL have port wdata_i, input, 32, store data from EX/MEM.
REQ-008 The block SHALL have port mem_ack_i, input, 1, memory completion strobe.
REQ-009 The block SHALL have port mem_rdata_i, input, 32, memory read data; valid only with mem_ack_i.
REQ-010 The block SHALL have port mem_req_o, output, 1, memory request.
REQ-011 The block SHALL have port mem_we_o, output, 1, 1 = write, 0 = read.
REQ-012 The block SHALL have port mem_addr_o, output, 32, registered address.
REQ-013 The block SHALL have port mem_wdata_o, output, 32, registered store data.
REQ-014 The block SHALL have port rdata_o, output, 32, last completed load data.
REQ-015 The block SHALL have port stall_o, output, 1, freeze; drives stall_i of all pipeline registers.
REQ-016 The block SHALL have port err_o, output, 1, sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, DONE; 8-bit cycle counter cnt.
REQ-018 IDLE: if MemRead_i|MemWrite_i, next=ACCESS; capture addr_i->mem_addr_o, wdata_i->mem_wdata_o, MemWrite_i->mem_we_o; cnt<=0.
REQ-019 MemRead_i and MemWrite_i both high SHALL be treated as a write.
REQ-020 stall_o SHALL be combinational: 1 when (IDLE and (MemRead_i|MemWrite_i)) or ACCESS; 0 in DONE and idle-no-request.
REQ-021 mem_req_o SHALL be 1 exactly while in ACCESS; mem_addr_o, mem_we_o and mem_wdata_o SHALL be stable throughout ACCESS.
REQ-022 ACCESS with mem_ack_i=1: next=DONE; if read, rdata_o<=mem_rdata_i.
REQ-023 ACCESS with mem_ack_i=0 and cnt==TIMEOUT-1: next=DONE, err_o<=1, rdata_o<=0 if read; otherwise cnt<=cnt+1.
REQ-024 ack and terminal count in the same cycle: ack SHALL win; no error.
REQ-025 DONE SHALL always go to IDLE after 1 cycle; stall_o=0 lets the pipeline advance once, so a completed access is never reissued.
REQ-026 Latency: request visible in cycle 0, ack in ACCESS cycle k (k>=1) gives stall_o high cycles 0..k and low in cycle k+1 (DONE).
REQ-027 Minimum spacing of back-to-back memory ops: 3 cycles each (IDLE, ACCESS, DONE).
REQ-028 mem_ack_i and mem_rdata_i SHALL be ignored in IDLE and DONE.
REQ-029 rdata_o SHALL be unchanged by writes and hold until the next read completes.
REQ-030 err_o, once set, SHALL remain 1 until reset.

Reset
REQ-031 rst_i=0 SHALL immediately, asynchronously force: state IDLE, cnt=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0.
REQ-032 During reset, stall_o SHALL follow REQ-020 from IDLE.
REQ-033 Reset during ACCESS SHALL abandon the access; no rdata_o update and no err_o.

Verification
REQ-034 Load: MemRead_i=1, addr_i=0x100, ack on 2nd ACCESS cycle with rdata 0xDEADBEEF -> mem_req_o 2 cycles, stall_o 3 cycles, rdata_o=0xDEADBEEF, err_o=0.
REQ-035 Store: MemWrite_i=1, addr_i=0x40, wdata_i=0x12345678, ack on 1st ACCESS cycle -> mem_we_o=1, mem_wdata_o=0x12345678, rdata_o unchanged.
REQ-036 Timeout: TIMEOUT=4, load, no ack -> mem_req_o exactly 4 cycles, then DONE, err_o=1 sticky, rdata_o=0.
REQ-037 Race: TIMEOUT=4, ack in the 4th ACCESS cycle -> no error, data captured.
REQ-038 Back-to-back: load then store in consecutive EX/MEM slots -> two distinct requests separated by one DONE cycle; no duplicate request.
REQ-039 Reset mid-access: rst_i=0 in ACCESS cycle 2 -> mem_req_o drops before the next edge, all outputs at reset values, and a new request after release proceeds normally.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// Stalls the pipeline while one EX/MEM load or store goes to memory. The access
// is aborted with a sticky error if no ack arrives within TIMEOUT cycles.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  dbg_state_o
);

    // Handshake: the pipeline holds MemRead_i/MemWrite_i steady while stall_o is 1.
    // mem_req_o stays high with stable address/data until mem_ack_i or timeout.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        op_req;

    assign op_req = MemRead_i | MemWrite_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (op_req) begin
                    state_d = ACCESS;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;
                    cnt_d   = 8'd0;
                end
            end
            ACCESS: begin
                // An ack on the terminal-count cycle still counts as success.
                if (mem_ack_i) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata_i;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req_o   = (state_q == ACCESS);
    assign stall_o     = ((state_q == IDLE) && op_req) || (state_q == ACCESS);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: a driver emulates a stalled EX/MEM stage and
// memory, a monitor checks each request and completion against a transaction model.
module tb_mem_stall_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // {we, addr, wdata} per request, {len, err, rdata} per completion
  logic [64:0] exp_req_q[$];
  logic [40:0] exp_done_q[$];

  logic        m_err = 1'b0;
  logic [31:0] m_rdata = '0;

  mem_stall_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .MemRead_i   (mem_read),
    .MemWrite_i  (mem_write),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .rdata_o     (rdata),
    .stall_o     (stall),
    .err_o       (err),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one memory op held until the pipeline is released; k = ack cycle (0 = none)
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int k, input logic [31:0] rd_data);
    logic acked;
    int   len;
    int   j;
    bit   done;
    acked = (k >= 1) && (k <= TO);
    len   = acked ? k : TO;
    if (!acked) m_err = 1'b1;
    if (!wr) m_rdata = acked ? rd_data : 32'd0;
    exp_req_q.push_back({wr, a, wd});
    exp_done_q.push_back({8'(len), m_err, m_rdata});
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    j = 0;
    done = 0;
    while (!done && j < 300) begin
      @(posedge clk);
      j++;
      @(negedge clk);
      if (!stall) done = 1;
      else begin
        mem_ack   = (j == k);
        mem_rdata = (j == k) ? rd_data : $urandom;
      end
    end
    if (!done) chk("op_completes", 64'd0, 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   64'(mem_req),   64'd0);
    chk({tag, "_we"},    64'(mem_we),    64'd0);
    chk({tag, "_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rdata"}, 64'(rdata),     64'd0);
    chk({tag, "_err"},   64'(err),       64'd0);
    chk({tag, "_stall"}, 64'(stall),     64'(mem_read | mem_write));
  endtask

  task automatic reset_mid_access(input logic [31:0] a);
    exp_req_q.push_back({1'b0, a, 32'd0});
    @(negedge clk);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = a;
    wdata     = 32'd0;
    mem_ack   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    m_err   = 1'b0;
    m_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #2;
    mem_read = 1'b0;
    rst_n    = 1'b1;
  endtask

  // monitor / scoreboard
  logic        prev_req = 1'b0;
  int          req_len = 0;
  int          stall_run = 0;
  logic [64:0] cur_req = '0;
  logic [40:0] cur_done = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_low", 64'(mem_req), 64'd0);
      chk("rst_stall",   64'(stall),   64'(mem_read | mem_write));
      prev_req  = 1'b0;
      req_len   = 0;
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (mem_req) begin
        if (!prev_req) begin
          if (exp_req_q.size() == 0) begin
            chk("req_unexpected", 64'd1, 64'd0);
            cur_req = {mem_we, mem_addr, mem_wdata};
          end else cur_req = exp_req_q.pop_front();
          req_len = 0;
        end
        req_len++;
        chk("req_we",    64'(mem_we),    64'(cur_req[64]));
        chk("req_addr",  64'(mem_addr),  64'(cur_req[63:32]));
        chk("req_wdata", 64'(mem_wdata), 64'(cur_req[31:0]));
        chk("req_stall", 64'(stall),     64'd1);
      end else if (prev_req) begin
        if (exp_done_q.size() == 0) begin
          chk("done_unexpected", 64'd1, 64'd0);
        end else begin
          cur_done = exp_done_q.pop_front();
          chk("req_cycles",  64'(req_len),   64'(cur_done[40:33]));
          chk("done_err",    64'(err),       64'(cur_done[32]));
          chk("done_rdata",  64'(rdata),     64'(cur_done[31:0]));
          chk("done_stall",  64'(stall),     64'd0);
          chk("stall_cycles", 64'(stall_run), 64'(cur_done[40:33]) + 64'd1);
        end
        stall_run = 0;
      end else begin
        chk("idle_stall", 64'(stall), 64'(mem_read | mem_write));
      end
      prev_req = mem_req;
    end
  end

  // stimulus
  initial begin
    int op;
    #3 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    issue(1'b1, 1'b0, 32'h100, 32'h0,        2, 32'hDEADBEEF);  // load
    idle(1);
    issue(1'b0, 1'b1, 32'h40,  32'h12345678, 1, 32'hA5A5A5A5);  // store
    idle(1);
    issue(1'b1, 1'b0, 32'h200, 32'h0,        TO, 32'hCAFEF00D); // ack on terminal count
    idle(1);
    issue(1'b1, 1'b0, 32'h300, 32'h0,        0, 32'h0);         // timeout
    idle(2);
    issue(1'b1, 1'b0, 32'h404, 32'h0,        1, 32'h11112222);  // back-to-back pair
    issue(1'b0, 1'b1, 32'h408, 32'h55667788, 3, 32'h0);
    issue(1'b1, 1'b1, 32'h40C, 32'h99AABBCC, 2, 32'hFFFF0000);  // both flags: write
    reset_mid_access(32'h500);
    idle(1);
    issue(1'b1, 1'b0, 32'h600, 32'h0,        2, 32'h0BADC0DE);

    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(1, 3);
      issue(op[0], op[1], $urandom, $urandom, $urandom_range(0, TO + 1), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    chk("req_queue_empty",  64'(exp_req_q.size()),  64'd0);
    chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
